// File: rtl/educell_spikegen_seq.sv
// educell_spikegen_seq: registered spike generator for one EDU decoding cell.
// Fires once per assertion episode of the cell's source condition. The spike
// is fanned out through a loadable direction mask. A holdoff window follows
// each fire, and a saturating counter tallies the fires.
module educell_spikegen_seq #(
    parameter int          NDIR        = 6,
    parameter int          ESM_W       = 3,
    parameter int          HOLDOFF     = 2,
    parameter int          CNT_W       = 8,
    parameter logic [2:0]  ST_SOURCE   = 3'd1,
    parameter logic [2:0]  ST_BOUNDARY = 3'd2,
    parameter logic [2:0]  ST_TRANSMIT = 3'd3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       state,
    input  logic [ESM_W-1:0] delayed_esmval,
    input  logic             delayed_bdval,
    input  logic             spike_taken,
    input  logic [NDIR-1:0]  spikedir_in,
    input  logic             spikedir_we,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [NDIR-1:0]  spike_out,
    output logic [NDIR-1:0]  spikedir_reg,
    output logic             busy,
    output logic [CNT_W-1:0] spike_cnt
);

    // The hold counter must represent HOLDOFF. Keep at least one bit so the
    // zero-holdoff build still has a legal vector.
    localparam int               HOLD_W    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic              src;
    logic              fire;
    logic              armed;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_next;
    logic [NDIR-1:0]   mask;
    logic [CNT_W-1:0]  cnt_next;

    assign spikedir_reg = mask;

    // Select the source term that matches the cell's role. Unknown states never fire.
    always_comb begin
        src = 1'b0;
        case (state)
            ST_SOURCE:   src = |delayed_esmval;
            ST_BOUNDARY: src = delayed_bdval;
            ST_TRANSMIT: src = spike_taken;
            default:     src = 1'b0;
        endcase
    end

    // A fire needs a fresh episode (armed) and an expired holdoff. A flush suppresses it.
    assign fire = src & armed & (hold == '0) & ~flush;

    // Next holdoff value. busy is registered from this value so that busy tracks hold exactly.
    always_comb begin
        hold_next = hold;
        if (flush)
            hold_next = '0;
        else if (fire)
            hold_next = HOLD_LOAD;
        else if (hold != '0)
            hold_next = hold - HOLD_ONE;
    end

    // Saturating fire counter. A clear on the same edge as a fire leaves the count at one.
    always_comb begin
        cnt_next = spike_cnt;
        if (cnt_clr)
            cnt_next = fire ? CNT_ONE : '0;
        else if (fire && (spike_cnt != CNT_MAX))
            cnt_next = spike_cnt + CNT_ONE;
    end

    // Episode tracking and the one-cycle spike pulse.
    // The pulse uses the mask as it stood before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed     <= 1'b1;
            spike_out <= '0;
        end else if (flush) begin
            armed     <= 1'b0;
            spike_out <= '0;
        end else if (fire) begin
            armed     <= 1'b0;
            spike_out <= mask;
        end else begin
            spike_out <= '0;
            if (!src)
                armed <= 1'b1;
        end
    end

    // Holdoff counter, busy flag and spike counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= '0;
            busy      <= 1'b0;
            spike_cnt <= '0;
        end else begin
            hold      <= hold_next;
            busy      <= (hold_next != '0);
            spike_cnt <= cnt_next;
        end
    end

    // Direction mask load. The load is independent of flush and of fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mask <= '0;
        else if (spikedir_we)
            mask <= spikedir_in;
    end

endmodule

// File: tb/tb_educell_spikegen_seq.sv
// Self-checking bench for educell_spikegen_seq.
// The reference model tracks episodes and the cycle index of the last fire.
// Directed scenarios are followed by randomized traffic.
module tb_educell_spikegen_seq;
    localparam int NDIR    = 6;
    localparam int ESM_W   = 3;
    localparam int HOLDOFF = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [2:0] ST_SOURCE   = 3'd1;
    localparam logic [2:0] ST_BOUNDARY = 3'd2;
    localparam logic [2:0] ST_TRANSMIT = 3'd3;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       state;
    logic [ESM_W-1:0] delayed_esmval;
    logic             delayed_bdval;
    logic             spike_taken;
    logic [NDIR-1:0]  spikedir_in;
    logic             spikedir_we;
    logic             flush;
    logic             cnt_clr;
    logic [NDIR-1:0]  spike_out;
    logic [NDIR-1:0]  spikedir_reg;
    logic             busy;
    logic [CNT_W-1:0] spike_cnt;

    // Clock and DUT
    always #5 clk = ~clk;

    educell_spikegen_seq #(
        .NDIR(NDIR), .ESM_W(ESM_W), .HOLDOFF(HOLDOFF), .CNT_W(CNT_W),
        .ST_SOURCE(ST_SOURCE), .ST_BOUNDARY(ST_BOUNDARY), .ST_TRANSMIT(ST_TRANSMIT)
    ) dut (
        .clk(clk), .rst(rst), .state(state), .delayed_esmval(delayed_esmval),
        .delayed_bdval(delayed_bdval), .spike_taken(spike_taken),
        .spikedir_in(spikedir_in), .spikedir_we(spikedir_we), .flush(flush),
        .cnt_clr(cnt_clr), .spike_out(spike_out), .spikedir_reg(spikedir_reg),
        .busy(busy), .spike_cnt(spike_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    // m_used: the current src episode has already been consumed by a fire or a flush.
    // m_last_fire: index of the edge that last fired (far in the past if none).
    bit              m_used;
    int              m_last_fire;
    int              m_edge;
    int              m_cnt;
    logic [NDIR-1:0] m_mask;
    logic [NDIR-1:0] m_spike;
    bit              m_busy;
    bit              m_fire;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit model_src();
        case (state)
            ST_SOURCE:   return delayed_esmval != '0;
            ST_BOUNDARY: return delayed_bdval;
            ST_TRANSMIT: return spike_taken;
            default:     return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_used      = 1'b0;
        m_last_fire = -1000;
        m_edge      = 0;
        m_cnt       = 0;
        m_mask      = '0;
        m_spike     = '0;
        m_busy      = 1'b0;
        m_fire      = 1'b0;
    endtask

    // Advance the model over one rising edge using the inputs currently applied.
    task automatic model_edge();
        bit s;
        s = model_src();
        m_edge++;
        m_fire = s && !m_used && ((m_edge - m_last_fire) > HOLDOFF) && !flush;
        if (flush) begin
            m_used      = 1'b1;
            m_last_fire = -1000;
            m_spike     = '0;
        end else if (m_fire) begin
            m_used      = 1'b1;
            m_last_fire = m_edge;
            m_spike     = m_mask;
        end else begin
            m_spike = '0;
            if (!s) m_used = 1'b0;
        end
        if (spikedir_we) m_mask = spikedir_in;
        if (cnt_clr)     m_cnt = m_fire ? 1 : 0;
        else if (m_fire) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        m_busy = (m_edge - m_last_fire) < HOLDOFF;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".spike"}, 32'(spike_out),    32'(m_spike));
        check({tag, ".mask"},  32'(spikedir_reg), 32'(m_mask));
        check({tag, ".busy"},  32'(busy),         32'(m_busy));
        check({tag, ".cnt"},   32'(spike_cnt),    32'(m_cnt));
    endtask

    // Driver: inputs are applied at the falling edge. One rising edge follows,
    // and the outputs are sampled at the next falling edge.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic clear_inputs();
        state = 3'd0; delayed_esmval = '0; delayed_bdval = 1'b0; spike_taken = 1'b0;
        spikedir_in = '0; spikedir_we = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        int c0;
        bit pat [4];
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single fire from a held source level, through mask 100001.
        spikedir_in = 6'b100001; spikedir_we = 1'b1;
        step("t1.load");
        spikedir_we = 1'b0;
        state = ST_SOURCE; delayed_esmval = 3'b010;
        for (int i = 0; i < 10; i++) begin
            step("t1.hold");
            if (i == 0) check("t1.first", 32'(spike_out), 32'(6'b100001));
            if (i == 1) check("t1.second", 32'(spike_out), 32'd0);
        end
        check("t1.cnt", 32'(spike_cnt), 32'd1);

        // Transmit pulses 1,0,1,1: the fire in the holdoff window is deferred to edge 3.
        state = 3'd0; delayed_esmval = '0; cnt_clr = 1'b1;
        step("t2.clr");
        cnt_clr = 1'b0;
        state = ST_TRANSMIT;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            spike_taken = pat[i];
            step("t2.seq");
            check("t2.spike", 32'(spike_out), (i == 0 || i == 3) ? 32'(6'b100001) : 32'd0);
            check("t2.busy", 32'(busy), (i == 0 || i == 1 || i == 3) ? 32'd1 : 32'd0);
        end
        check("t2.cnt", 32'(spike_cnt), 32'd2);

        // A fire and a mask load on the same edge: the spike uses the old mask.
        spike_taken = 1'b0;
        step("t3.low"); step("t3.low");
        spike_taken = 1'b1; spikedir_in = 6'b000011; spikedir_we = 1'b1;
        step("t3.fire");
        check("t3.oldmask", 32'(spike_out), 32'(6'b100001));
        check("t3.newmask", 32'(spikedir_reg), 32'(6'b000011));
        spikedir_we = 1'b0; spike_taken = 1'b0;
        for (int i = 0; i < 3; i++) step("t3.idle");

        // A flush on the rising edge of src consumes the episode.
        c0 = m_cnt;
        spike_taken = 1'b1; flush = 1'b1;
        step("t4.flush");
        check("t4.nospike", 32'(spike_out), 32'd0);
        flush = 1'b0;
        for (int i = 0; i < 5; i++) step("t4.high");
        check("t4.cnt_same", 32'(spike_cnt), 32'(c0));
        spike_taken = 1'b0; step("t4.low");
        spike_taken = 1'b1; step("t4.rise");
        check("t4.spike", 32'(spike_out), 32'(6'b000011));
        check("t4.cnt_inc", 32'(spike_cnt), 32'(c0 + 1));

        // Counter saturation, then clear with and without a simultaneous fire.
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            spike_taken = 1'b1; step("t5.hi");
            spike_taken = 1'b0; step("t5.lo"); step("t5.lo");
        end
        check("t5.sat", 32'(spike_cnt), 32'(CNT_MAX));
        spike_taken = 1'b1; cnt_clr = 1'b1;
        step("t5.clrfire");
        check("t5.clrfire", 32'(spike_cnt), 32'd1);
        spike_taken = 1'b0;
        step("t5.clr");
        check("t5.clr", 32'(spike_cnt), 32'd0);
        cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) step("t5.idle");

        // Boundary role follows only bdval; an undefined state never fires and re-arms.
        state = ST_BOUNDARY; delayed_esmval = 3'b111; delayed_bdval = 1'b0; spike_taken = 1'b1;
        step("t6.bd0"); step("t6.bd0");
        check("t6.bd0", 32'(spike_cnt), 32'd0);
        delayed_bdval = 1'b1;
        step("t6.bd1");
        check("t6.bd1", 32'(spike_cnt), 32'd1);
        state = 3'd6;
        for (int i = 0; i < 4; i++) step("t6.undef");
        check("t6.undef", 32'(spike_cnt), 32'd1);
        state = ST_BOUNDARY;
        step("t6.back");
        check("t6.rearm", 32'(spike_cnt), 32'd2);

        // An asynchronous reset during the pulse and holdoff clears everything at once.
        // An already-high src then fires on the first edge after release.
        state = 3'd0; step("t7.low");
        state = ST_TRANSMIT; spike_taken = 1'b1;
        step("t7.fire");
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all("t7.async");
        check("t7.busy0", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        compare_all("t7.inrst");
        rst = 1'b0;
        step("t7.refire");
        check("t7.refire", 32'(spike_cnt), 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) state = 3'($urandom_range(0, 7));
            delayed_esmval = ($urandom_range(0, 1) == 0) ? '0 : ESM_W'($urandom);
            delayed_bdval  = 1'($urandom);
            spike_taken    = 1'($urandom);
            flush          = ($urandom_range(0, 15) == 0);
            cnt_clr        = ($urandom_range(0, 63) == 0);
            spikedir_we    = ($urandom_range(0, 7) == 0);
            spikedir_in    = NDIR'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                compare_all("rand.rst");
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
            end else begin
                step("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/educell_spikegen_seq.md
# educell_spikegen_seq

Registered, parametrised spike generator for one EDU decoding cell. It replaces the purely combinational forwarding stage. It fires one spike per assertion episode of the cell's source condition and fans that spike out over a configurable number of directions through a loadable direction mask. A post-fire holdoff window and a saturating spike counter support decoder-level statistics. It sits between the cell's state/ESM logic and the inter-cell spike wiring of the EDU mesh.

## Interface
- NDIR, 6, number of spike output directions (bit NDIR-1 = first direction, e.g. nw … s for 6)
- ESM_W, 3, width of the delayed ESM value (aqmeas threshold)
- HOLDOFF, 2, cycles after a fire during which no new fire is allowed (0 = none)
- CNT_W, 8, width of saturating spike counter
- ST_SOURCE, 3'd1, state code: source cell
- ST_BOUNDARY, 3'd2, state code: boundary cell
- ST_TRANSMIT, 3'd3, state code: transmit cell

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- state  input  3  cell state
- delayed_esmval  input  ESM_W  delayed ESM measurement bits
- delayed_bdval  input  1  delayed boundary value
- spike_taken  input  1  incoming spike accepted by this cell
- spikedir_in  input  NDIR  new direction mask
- spikedir_we  input  1  load spikedir_in into mask
- flush  input  1  synchronous abort of current episode
- cnt_clr  input  1  synchronous clear of spike counter
- spike_out  output  NDIR  registered one-cycle spike per direction
- spikedir_reg  output  NDIR  current direction mask
- busy  output  1  holdoff window active
- spike_cnt  output  CNT_W  saturating count of fires

## Operation
- Source term src (combinational):
  - ST_SOURCE: OR of delayed_esmval
  - ST_BOUNDARY: delayed_bdval
  - ST_TRANSMIT: spike_taken
  - any other state: 0
- Internal regs: armed (1b), hold (counter, width to hold HOLDOFF), mask (NDIR).
- fire = src & armed & (hold == 0) & ~flush.
- Per clock edge, in priority order:
  - flush: armed<=0, hold<=0, spike_out<=0.
  - else if fire: spike_out<=mask (pre-update value), armed<=0, hold<=HOLDOFF.
  - else: spike_out<=0; hold decrements if nonzero; armed<=1 when src==0.
- Re-arm rule:
  - armed clears only on fire or flush.
  - src low at any edge (including during holdoff) re-arms.
  - A rise that occurs during holdoff fires on the first edge where hold==0, provided armed is set and src is still high.
- Mask: spikedir_we loads mask<=spikedir_in, independent of flush. A fire on the same edge uses the old mask.
- busy is registered: high exactly while hold != 0.
- spike_cnt:
  - Increments by 1 on fire and saturates at 2^CNT_W-1.
  - cnt_clr with fire on the same edge gives 1; cnt_clr alone gives 0.
  - flush does not affect the count.
- A fire with mask==0 still counts and starts holdoff; spike_out stays 0.

## Timing
- Reset (async, immediate):
  - spike_out=0, spikedir_reg=0, spike_cnt=0, busy=0
  - armed=1, hold=0
- Latency: src high before edge t (armed, hold 0) gives spike_out=mask for exactly the cycle after edge t.
- The minimum spacing between fires is HOLDOFF+1 cycles. With HOLDOFF=0, src toggling 1,0,1 fires every other cycle.
- src held high indefinitely produces exactly one fire.
- Reset asserted mid-holdoff or mid-pulse clears everything within the same cycle. After release, an already-high src fires on the first edge.
- State changes are treated as ordinary src changes; there is no implicit re-arm.

## Test plan
- Reset, mask=6'b100001, ST_SOURCE, delayed_esmval=3'b010 held 10 cycles -> spike_out=6'b100001 for exactly one cycle, one cycle after the first edge; spike_cnt=1.
- HOLDOFF=2, ST_TRANSMIT, spike_taken pulsed on cycles 0,1,2,3 (drops 1 cycle, rises) -> fire at edge 0, busy 2 cycles, second fire at edge 3 (first edge with hold==0 and armed), cnt=2.
- Fire and spikedir_we with new mask 6'b000011 on the same edge -> spike uses old mask; spikedir_reg=6'b000011 next cycle.
- flush on the edge where src rises -> no spike, armed=0; src stays high 5 cycles -> no spike; src low then high -> one spike.
- CNT_W=2, 5 separated fires -> spike_cnt saturates at 3; cnt_clr with a fire -> 1.
- ST_BOUNDARY with delayed_bdval=1 and esmval nonzero, then an undefined state code -> only bdval drives a fire; undefined state never fires and re-arms.
